// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its iteration datapath.
package alu_pkg;

  // Operation select presented on the func port.
  typedef enum logic [2:0] {
    RA   = 3'd0,
    RB   = 3'd1,
    RNOP = 3'd2,
    RADD = 3'd3,
    RSUB = 3'd4,
    RMUL = 3'd5,
    RDIV = 3'd6
  } alu_op_t;

  // Bit positions inside the 4-bit {V,N,Z,C} flags word.
  localparam int FV = 3;
  localparam int FN = 2;
  localparam int FZ = 1;
  localparam int FC = 0;

  // Controller states. FIN is the cycle in which an iterative result is presented.
  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath shared by multiply (shift-add) and unsigned divide (restoring).
// lo/hi show the value the registers will hold after the step applied this cycle,
// so the controller can register the final result on the same edge as the last step.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         step,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         last
);

  logic [N:0]       r_acc;
  logic [N-1:0]     r_q;
  logic [N-1:0]     r_opB;
  logic [CNT_W-1:0] r_cnt;

  logic [N:0]       w_sum;
  logic [N:0]       w_pick;
  logic [N:0]       w_shift;
  logic [N:0]       w_trial;
  logic [N:0]       w_nextAcc;
  logic [N-1:0]     w_nextQ;

  // One iteration: mode=0 adds and shifts the product right, mode=1 shifts the remainder left and trial-subtracts.
  always_comb begin
    w_sum   = r_acc + {1'b0, r_opB};
    w_pick  = r_q[0] ? w_sum : r_acc;
    w_shift = {r_acc[N-1:0], r_q[N-1]};
    w_trial = w_shift - {1'b0, r_opB};
    if (mode) begin
      if (!w_trial[N]) begin
        w_nextAcc = w_trial;
        w_nextQ   = {r_q[N-2:0], 1'b1};
      end else begin
        w_nextAcc = w_shift;
        w_nextQ   = {r_q[N-2:0], 1'b0};
      end
    end else begin
      w_nextAcc = {1'b0, w_pick[N:1]};
      w_nextQ   = {w_pick[0], r_q[N-1:1]};
    end
  end

  assign lo   = w_nextQ;
  assign hi   = w_nextAcc[N-1:0];
  assign last = (r_cnt == CNT_W'(1));

  // Accumulator, shifting operand and iteration counter; load primes them, step advances one iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_q   <= '0;
      r_opB <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_acc <= '0;
      r_q   <= a;
      r_opB <= b;
      r_cnt <= CNT_W'(N);
    end else if (step) begin
      r_acc <= w_nextAcc;
      r_q   <= w_nextQ;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/pass, iterative signed multiply and unsigned divide.
// All outputs are registered; done pulses for exactly one cycle per accepted start.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  alu_op_t      func,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic [N-1:0] out_hi,
  output logic [3:0]   flags
);

  state_t         r_state;
  state_t         w_nextState;
  logic           w_isIter;
  logic           w_load;
  logic           w_step;
  logic           w_quick;
  logic           w_finish;
  logic           w_last;

  logic           r_isDiv;
  logic           r_neg;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_out;
  logic [N-1:0]   r_hi;
  logic [3:0]     r_flags;

  logic [N-1:0]   w_opA;
  logic [N-1:0]   w_opB;
  logic [N-1:0]   w_lo;
  logic [N-1:0]   w_hi;

  logic [N:0]     w_addSum;
  logic [N:0]     w_subDiff;
  logic [N-1:0]   w_qOut;
  logic [N-1:0]   w_qHi;
  logic           w_qV;
  logic           w_qC;

  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_fixed;
  logic [N-1:0]   w_fOut;
  logic [N-1:0]   w_fHi;
  logic           w_fV;

  function automatic logic [3:0] packFlags(input logic v, input logic [N-1:0] res, input logic c);
    logic [3:0] f;
    f     = '0;
    f[FV] = v;
    f[FN] = res[N-1];
    f[FZ] = (res == '0);
    f[FC] = c;
    return f;
  endfunction

  // Divide by zero is answered immediately, so only a real divide or a multiply iterates.
  assign w_isIter = (func == RMUL) || ((func == RDIV) && (b != '0));

  // Multiply iterates on magnitudes; the sign is restored when the result is registered.
  assign w_opA = ((func == RMUL) && a[N-1]) ? -a : a;
  assign w_opB = ((func == RMUL) && b[N-1]) ? -b : b;

  alu_seq_muldiv #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .mode  (r_isDiv),
    .a     (w_opA),
    .b     (w_opB),
    .step  (w_step),
    .lo    (w_lo),
    .hi    (w_hi),
    .last  (w_last)
  );

  // State register for the IDLE -> ITER -> FIN controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control strobes; FIN accepts a new start just like IDLE so back-to-back ops lose no cycle.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_quick     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE, FIN: begin
        w_nextState = IDLE;
        if (start) begin
          if (w_isIter) begin
            w_load      = 1'b1;
            w_nextState = ITER;
          end else begin
            w_quick = 1'b1;
          end
        end
      end
      ITER: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_nextState = FIN;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Single-cycle results, including the divide-by-zero answer.
  always_comb begin
    w_addSum  = {1'b0, a} + {1'b0, b};
    w_subDiff = {1'b0, a} - {1'b0, b};
    w_qOut    = '0;
    w_qHi     = '0;
    w_qV      = 1'b0;
    w_qC      = 1'b0;
    case (func)
      RA: w_qOut = a;
      RB: w_qOut = b;
      RADD: begin
        w_qOut = w_addSum[N-1:0];
        w_qC   = w_addSum[N];
        w_qV   = (a[N-1] == b[N-1]) && (w_addSum[N-1] != a[N-1]);
      end
      RSUB: begin
        w_qOut = w_subDiff[N-1:0];
        w_qC   = w_subDiff[N];
        w_qV   = (a[N-1] != b[N-1]) && (w_subDiff[N-1] != a[N-1]);
      end
      RDIV: begin
        w_qOut = '1;
        w_qHi  = a;
        w_qV   = 1'b1;
      end
      default: ;
    endcase
  end

  // Final iterative result: sign-fix the 2N-bit product, or pass quotient/remainder straight through.
  always_comb begin
    w_prod  = {w_hi, w_lo};
    w_fixed = r_neg ? -w_prod : w_prod;
    if (r_isDiv) begin
      w_fOut = w_lo;
      w_fHi  = w_hi;
      w_fV   = 1'b0;
    end else begin
      w_fOut = w_fixed[N-1:0];
      w_fHi  = w_fixed[2*N-1:N];
      w_fV   = (w_fHi != {N{w_fOut[N-1]}});
    end
  end

  // Output registers, done pulse, busy and the per-op attributes captured at start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_hi    <= '0;
      r_flags <= '0;
      r_isDiv <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_quick) begin
        r_out   <= w_qOut;
        r_hi    <= w_qHi;
        r_flags <= packFlags(w_qV, w_qOut, w_qC);
        r_done  <= 1'b1;
      end else if (w_finish) begin
        r_out   <= w_fOut;
        r_hi    <= w_fHi;
        r_flags <= packFlags(w_fV, w_fOut, 1'b0);
        r_done  <= 1'b1;
      end
      if (w_load) begin
        r_busy  <= 1'b1;
        r_isDiv <= (func == RDIV);
        r_neg   <= (func == RMUL) && (a[N-1] ^ b[N-1]);
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign out    = r_out;
  assign out_hi = r_hi;
  assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8): vector table, random ops against a behavioural model,
// and hand-written restart and mid-op reset sequences. Results are matched through a scoreboard queue.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  alu_op_t    func;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic [7:0] out_hi;
  logic [3:0] flags;

  typedef struct {
    alu_op_t    f;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic [7:0] eh;
    logic [3:0] ef;
    int         lat;
  } vec_t;

  typedef struct {
    string      tag;
    logic [7:0] eo;
    logic [7:0] eh;
    logic [3:0] ef;
    int         lat;
    int         startEdge;
  } exp_t;

  exp_t sbQ[$];
  vec_t table_v[15];
  int   checks    = 0;
  int   errors    = 0;
  int   edgeCnt   = 0;
  int   doneCount = 0;

  alu_seq #(.N(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .func   (func),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .out_hi (out_hi),
    .flags  (flags)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to time-stamp starts and measure latency.
  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse pops the oldest expectation and compares results and latency.
  always @(negedge clk) begin
    if (!reset && done) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_done: got done=1 with %0d pending, expected no pulse", sbQ.size());
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput({e.tag, ".out"},     16'(out),    16'(e.eo));
        checkOutput({e.tag, ".out_hi"},  16'(out_hi), 16'(e.eh));
        checkOutput({e.tag, ".flags"},   16'(flags),  16'(e.ef));
        checkOutput({e.tag, ".latency"}, 16'(edgeCnt - e.startEdge), 16'(e.lat));
      end
    end
  end

  function automatic vec_t model(input alu_op_t f, input logic [7:0] av, input logic [7:0] bv);
    vec_t v;
    int sa, sb, r;
    logic [15:0] p;
    logic [8:0] s;
    v.f = f; v.a = av; v.b = bv;
    v.eo = '0; v.eh = '0; v.ef = '0; v.lat = 1;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    case (f)
      RA: v.eo = av;
      RB: v.eo = bv;
      RADD: begin
        r = sa + sb;
        s = {1'b0, av} + {1'b0, bv};
        v.eo = s[7:0];
        v.ef[FC] = s[8];
        v.ef[FV] = (r > 127) || (r < -128);
      end
      RSUB: begin
        r = sa - sb;
        v.eo = av - bv;
        v.ef[FC] = (av < bv);
        v.ef[FV] = (r > 127) || (r < -128);
      end
      RMUL: begin
        r = sa * sb;
        p = 16'(r);
        v.eo = p[7:0];
        v.eh = p[15:8];
        v.ef[FV] = (r > 127) || (r < -128);
        v.lat = 9;
      end
      RDIV: begin
        if (bv == 8'd0) begin
          v.eo = 8'hFF;
          v.eh = av;
          v.ef[FV] = 1'b1;
        end else begin
          v.eo = av / bv;
          v.eh = av % bv;
          v.lat = 9;
        end
      end
      default: ;
    endcase
    v.ef[FN] = v.eo[7];
    v.ef[FZ] = (v.eo == 8'd0);
    return v;
  endfunction

  task automatic pushExp(input string tag, input vec_t v);
    exp_t e;
    e.tag = tag; e.eo = v.eo; e.eh = v.eh; e.ef = v.ef; e.lat = v.lat; e.startEdge = edgeCnt;
    sbQ.push_back(e);
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d results pending, expected 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    @(posedge clk); #1;
    func = v.f; a = v.a; b = v.b; start = 1'b1;
    pushExp(tag, v);
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain(40);
  endtask

  initial begin
    vec_t v;
    int dc;
    reset = 1'b1; start = 1'b0; func = RNOP; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy",   16'(busy),   16'd0);
    checkOutput("reset.done",   16'(done),   16'd0);
    checkOutput("reset.out",    16'(out),    16'd0);
    checkOutput("reset.out_hi", 16'(out_hi), 16'd0);
    checkOutput("reset.flags",  16'(flags),  16'd0);
    reset = 1'b0;

    // {func, a, b, out, out_hi, {V,N,Z,C}, latency}
    table_v[0]  = '{RADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1100, 1};
    table_v[1]  = '{RSUB, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0101, 1};
    table_v[2]  = '{RMUL, 8'hFD, 8'h05, 8'hF1, 8'hFF, 4'b0100, 9};
    table_v[3]  = '{RMUL, 8'h40, 8'h04, 8'h00, 8'h01, 4'b1010, 9};
    table_v[4]  = '{RMUL, 8'h80, 8'h80, 8'h00, 8'h40, 4'b1010, 9};
    table_v[5]  = '{RDIV, 8'd100, 8'd7, 8'h0E, 8'h02, 4'b0000, 9};
    table_v[6]  = '{RDIV, 8'd100, 8'd0, 8'hFF, 8'd100, 4'b1100, 1};
    table_v[7]  = '{RA,   8'h5A, 8'h33, 8'h5A, 8'h00, 4'b0000, 1};
    table_v[8]  = '{RB,   8'h5A, 8'h83, 8'h83, 8'h00, 4'b0100, 1};
    table_v[9]  = '{RNOP, 8'h5A, 8'h83, 8'h00, 8'h00, 4'b0010, 1};
    table_v[10] = '{RADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1};
    table_v[11] = '{RSUB, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1000, 1};
    table_v[12] = '{RMUL, 8'hFF, 8'hFF, 8'h01, 8'h00, 4'b0000, 9};
    table_v[13] = '{RDIV, 8'hFF, 8'h01, 8'hFF, 8'h00, 4'b0100, 9};
    table_v[14] = '{RDIV, 8'h05, 8'h09, 8'h00, 8'h05, 4'b0010, 9};

    for (int i = 0; i < 15; i++) begin
      applyStimulus($sformatf("vec%0d", i), table_v[i]);
    end

    for (int i = 0; i < 24; i++) begin
      alu_op_t rf;
      logic [7:0] ra, rb;
      rf = alu_op_t'(3'($urandom_range(0, 6)));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      applyStimulus($sformatf("rnd%0d", i), model(rf, ra, rb));
    end

    // Start held high through a multiply, operands changed mid-flight; the add is taken in the done cycle.
    @(posedge clk); #1;
    func = RMUL; a = 8'hFD; b = 8'h05; start = 1'b1;
    pushExp("restart.mul", model(RMUL, 8'hFD, 8'h05));
    @(posedge clk); #1;
    checkOutput("restart.busy_first", 16'(busy), 16'd1);
    func = RADD; a = 8'd3; b = 8'd4;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("restart.busy_last", 16'(busy), 16'd1);
    @(posedge clk); #1;
    checkOutput("restart.busy_in_done", 16'(busy), 16'd0);
    pushExp("restart.add", model(RADD, 8'd3, 8'd4));
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain(40);

    // Reset in the middle of a multiply: no done, outputs cleared.
    @(posedge clk); #1;
    func = RMUL; a = 8'hFD; b = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset.busy",  16'(busy),  16'd0);
    checkOutput("midreset.done",  16'(done),  16'd0);
    checkOutput("midreset.out",   16'(out),   16'd0);
    checkOutput("midreset.flags", 16'(flags), 16'd0);
    dc = doneCount;
    repeat (14) @(posedge clk);
    checkOutput("midreset.no_done", 16'(doneCount - dc), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
